jtopl_timer_bank: RTL

Parametrised timer bank for the JTOPL family, successor to the fixed two-timer OPL unit. Provides NTIM up-counting timers, each ticking at a power-of-two multiple of the sample rate (`zero` pulse), with per-timer periodic or one-shot mode, flag masking, flag clearing and a combined active-low IRQ. Sits beside `jtopl_mmr`, which drives its controls, and feeds status bits to the CPU read port.

---
 rtl/jtopl_timer_bank.sv | 111 +++++++++++
 1 files changed

// File: rtl/jtopl_timer_bank.sv
// jtopl_timer_bank
//   NTIM up-counting timers sharing one free-running sample prescaler.
//   Timer i ticks once every 2^(PRE_LOG+i*STEP_LOG) zero pulses, reloads
//   from its value slice on overflow, and can run periodic or one-shot.
//   Overflow events set sticky, maskable flags that are OR-ed into an
//   active-low IRQ.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   cenop       operator clock enable; gates every state change
//   zero        one-cenop pulse per sample
//   value       reload values, timer i at [i*W +: W]
//   load        per-timer run enable (level; rising edge reloads)
//   oneshot     per-timer stop after first overflow
//   flagen      per-timer overflow-sets-flag enable
//   clr_flag    per-timer flag clear request
//   flag        sticky overflow flags
//   overflow    overflow strobe, one cenop period wide
//   irq_n       active-low OR of all flags
module jtopl_timer_bank #(
  parameter int NTIM     = 2,
  parameter int W        = 8,
  parameter int PRE_LOG  = 2,
  parameter int STEP_LOG = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cenop,
  input  logic            zero,
  input  logic [NTIM*W-1:0] value,
  input  logic [NTIM-1:0] load,
  input  logic [NTIM-1:0] oneshot,
  input  logic [NTIM-1:0] flagen,
  input  logic [NTIM-1:0] clr_flag,
  output logic [NTIM-1:0] flag,
  output logic [NTIM-1:0] overflow,
  output logic            irq_n
);

  localparam int PW = PRE_LOG + (NTIM-1)*STEP_LOG;

  logic [PW-1:0] pre;

  // Shared prescaler: never touched by load, so timer phase is not aligned
  // to the load edge and the first period may be up to one tick short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pre <= '0;
    else if (cenop && zero)
      pre <= pre + PW'(1);
  end

  for (genvar i = 0; i < NTIM; i++) begin : g_tim
    localparam int TW = PRE_LOG + i*STEP_LOG;
    // Low TW prescaler bits select the tick; a mask avoids a zero-width
    // slice when TW is 0.
    localparam logic [PW-1:0] MASK = PW'((64'd1 << TW) - 64'd1);

    logic [W-1:0] val;
    logic [W-1:0] cnt;
    logic         load_l;
    logic         done;
    logic         flag_r;
    logic         ovf_r;
    logic         tick;
    logic         rise;
    logic         step;
    logic         ev;

    assign val  = value[i*W +: W];
    assign tick = cenop & zero & (&(pre | ~MASK));
    assign rise = load[i] & ~load_l;
    // A load edge wins over a coincident tick.
    assign step = ~rise & load[i] & ~done & tick;
    assign ev   = step & (&cnt);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        load_l <= 1'b0;
        done   <= 1'b0;
        flag_r <= 1'b0;
        ovf_r  <= 1'b0;
      end else if (cenop) begin
        load_l <= load[i];
        ovf_r  <= ev;
        if (rise) begin
          cnt  <= val;
          done <= 1'b0;
        end else if (step) begin
          if (&cnt) begin
            cnt <= val;
            if (oneshot[i])
              done <= 1'b1;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        if (ev && flagen[i])
          flag_r <= 1'b1;
        else if (clr_flag[i])
          flag_r <= 1'b0;
      end
    end

    assign flag[i]     = flag_r;
    assign overflow[i] = ovf_r;
  end

  assign irq_n = ~|flag;

endmodule
